// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates loader burst writes and reader burst reads onto one RAM port.
// Tie-break is round-robin when ARB_ROUND_ROBIN_EN is defined, otherwise fixed loader priority.
module mem_port_arbiter #(
  parameter int NUM_ADDR = 5,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_req,
  input  logic [NUM_ADDR-1:0] ld_addr,
  input  logic [NUM_ADDR-1:0] ld_len,
  input  logic [DATA_W-1:0]   ld_data,
  output logic                ld_gnt,
  output logic                ld_ack,
  output logic                ld_done,
  input  logic                rd_req,
  input  logic [NUM_ADDR-1:0] rd_addr,
  input  logic [NUM_ADDR-1:0] rd_len,
  output logic                rd_gnt,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_done,
  output logic [NUM_ADDR-1:0] mem_a,
  output logic                mem_csb,
  output logic                mem_web,
  output logic                mem_oeb,
  output logic [DATA_W-1:0]   mem_i,
  input  logic [DATA_W-1:0]   mem_o
);
  typedef enum logic [1:0] {IDLE, WR, RD, DRAIN} state_t;
  state_t state, state_nx;
  logic [NUM_ADDR-1:0] addr, cnt;
  logic ld_done_q, rd_valid_q, ld_win, rd_win, last;
`ifdef ARB_ROUND_ROBIN_EN
  logic ld_turn;
  // Whoever was just granted yields the next tie to the other side.
  always_ff @(posedge clk) begin
    if (rst) ld_turn <= 1'b1;
    else if (ld_win || rd_win) ld_turn <= rd_win;
  end
  assign ld_win = (state == IDLE) && ld_req && (!rd_req || ld_turn);
`else
  assign ld_win = (state == IDLE) && ld_req;
`endif
  assign rd_win = (state == IDLE) && rd_req && !ld_win;
  assign last = (cnt == '0);
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (ld_win ? WR : rd_win ? RD : IDLE) :
               (state == WR)   ? (last ? IDLE : WR) :
               (state == RD)   ? (last ? DRAIN : RD) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      cnt <= '0;
      ld_done_q <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state <= state_nx;
      ld_done_q <= (state == WR) && last;
      rd_valid_q <= (state == RD);
      if (ld_win) begin
        addr <= ld_addr;
        cnt <= ld_len;
      end else if (rd_win) begin
        addr <= rd_addr;
        cnt <= rd_len;
      end else if (state == WR || state == RD) begin
        addr <= addr + 1'b1;
        cnt <= cnt - 1'b1;
      end
    end
  end
  assign ld_gnt = (state == WR);
  assign ld_ack = (state == WR);
  assign ld_done = ld_done_q;
  assign rd_gnt = (state == RD) || (state == DRAIN);
  assign rd_valid = rd_valid_q;
  // RAM read data arrives the cycle after the access, so it is passed straight through.
  assign rd_data = rd_valid_q ? mem_o : '0;
  assign rd_done = (state == DRAIN);
  assign mem_a = addr;
  assign mem_csb = !(state == WR || state == RD);
  assign mem_web = (state != WR);
  assign mem_oeb = (state != RD);
  assign mem_i = (state == WR) ? ld_data : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table vectors, directed corner sequences and random traffic
// checked against a burst-level reference model and a synchronous RAM model.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst, ld_req, rd_req;
  logic [4:0] ld_addr, ld_len, rd_addr, rd_len, mem_a;
  logic [31:0] ld_data, rd_data, mem_i;
  logic [31:0] mem_o = '0;
  logic ld_gnt, ld_ack, ld_done, rd_gnt, rd_valid, rd_done, mem_csb, mem_web, mem_oeb;
  logic [31:0] ram [32] = '{default: '0};
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_ADDR(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_len(ld_len), .ld_data(ld_data),
    .ld_gnt(ld_gnt), .ld_ack(ld_ack), .ld_done(ld_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data), .rd_done(rd_done),
    .mem_a(mem_a), .mem_csb(mem_csb), .mem_web(mem_web), .mem_oeb(mem_oeb),
    .mem_i(mem_i), .mem_o(mem_o)
  );

  always @(posedge clk) begin
    if (!mem_csb) begin
      if (!mem_web) ram[mem_a] <= mem_i;
      else if (!mem_oeb) mem_o <= ram[mem_a];
    end
  end

  typedef struct {
    logic ld_gnt, ld_ack, ld_done, rd_gnt, rd_valid, rd_done, csb, web;
    logic [4:0] a;
    logic [31:0] i, rdata;
  } obs_t;
  obs_t o;

  typedef struct {
    logic [1:0] req;
    logic [4:0] addr, len;
    logic [31:0] d;
    logic [8:0] flags;
    logic [4:0] ea;
    logic [31:0] erd;
  } vec_t;
  vec_t tbl [11];

  int m_mode = 0, m_start = 0, m_n = 0, m_k = 0, m_pa = 0;
  bit m_pv = 1'b0, m_ldd = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
  bit m_ld_turn = 1'b1;
`endif
  logic [31:0] ref_mem [32] = '{default: '0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    bit wr, rd, dr;
    wr = (m_mode == 1);
    rd = (m_mode == 2);
    dr = (m_mode == 3);
    chk("ld_gnt", 32'(ld_gnt), 32'(wr));
    chk("ld_ack", 32'(ld_ack), 32'(wr));
    chk("ld_done", 32'(ld_done), 32'(m_ldd));
    chk("rd_gnt", 32'(rd_gnt), 32'(rd || dr));
    chk("rd_done", 32'(rd_done), 32'(dr));
    chk("rd_valid", 32'(rd_valid), 32'(m_pv));
    chk("rd_data", rd_data, m_pv ? ref_mem[m_pa] : 32'd0);
    chk("mem_csb", 32'(mem_csb), 32'(!(wr || rd)));
    chk("mem_web", 32'(mem_web), 32'(!wr));
    chk("mem_oeb", 32'(mem_oeb), 32'(!rd));
    chk("mem_i", mem_i, wr ? ld_data : 32'd0);
    if (wr || rd) chk("mem_a", 32'(mem_a), 32'((m_start + m_k) % 32));
  endtask

  task automatic advance();
    bit ldw, ld_pri;
    if (m_mode == 1) ref_mem[(m_start + m_k) % 32] = ld_data;
    if (rst) begin
      m_mode = 0;
      m_pv = 1'b0;
      m_ldd = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      m_ld_turn = 1'b1;
`endif
    end else begin
      m_pv = (m_mode == 2);
      m_pa = (m_start + m_k) % 32;
      m_ldd = (m_mode == 1) && (m_k + 1 == m_n);
      if (m_mode == 1 || m_mode == 2) begin
        m_k++;
        if (m_k == m_n) m_mode = (m_mode == 1) ? 0 : 3;
      end else if (m_mode == 3) begin
        m_mode = 0;
      end else if (ld_req || rd_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        ld_pri = m_ld_turn;
        m_ld_turn = !(ld_req && (!rd_req || ld_pri));
`else
        ld_pri = 1'b1;
`endif
        ldw = ld_req && (!rd_req || ld_pri);
        m_mode = ldw ? 1 : 2;
        m_start = ldw ? int'(ld_addr) : int'(rd_addr);
        m_n = (ldw ? int'(ld_len) : int'(rd_len)) + 1;
        m_k = 0;
      end
    end
  endtask

  task automatic step(input logic r, input logic lq, input logic [4:0] la, input logic [4:0] ll,
                      input logic [31:0] ldd, input logic rq, input logic [4:0] ra, input logic [4:0] rl);
    rst = r;
    ld_req = lq;
    ld_addr = la;
    ld_len = ll;
    ld_data = ldd;
    rd_req = rq;
    rd_addr = ra;
    rd_len = rl;
    @(negedge clk);
    o = '{ld_gnt, ld_ack, ld_done, rd_gnt, rd_valid, rd_done, mem_csb, mem_web, mem_a, mem_i, rd_data};
    check_model();
    advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
  endtask

  initial begin
    int wq[$];
    int gq[$];
    int exp_w [4];
    int exp_g [3];
    logic pl, pr;
    tbl[0]  = '{2'b10, 5'd3, 5'd2, 32'd0,         9'b000000110, 5'd0, 32'd0};
    tbl[1]  = '{2'b00, 5'd0, 5'd0, 32'hA0A0_0001, 9'b110000001, 5'd3, 32'd0};
    tbl[2]  = '{2'b00, 5'd0, 5'd0, 32'hB0B0_0002, 9'b110000001, 5'd4, 32'd0};
    tbl[3]  = '{2'b00, 5'd0, 5'd0, 32'hC0C0_0003, 9'b110000001, 5'd5, 32'd0};
    tbl[4]  = '{2'b00, 5'd0, 5'd0, 32'd0,         9'b001000110, 5'd0, 32'd0};
    tbl[5]  = '{2'b01, 5'd3, 5'd2, 32'd0,         9'b000000110, 5'd0, 32'd0};
    tbl[6]  = '{2'b00, 5'd0, 5'd0, 32'd0,         9'b000100011, 5'd3, 32'd0};
    tbl[7]  = '{2'b00, 5'd0, 5'd0, 32'd0,         9'b000110011, 5'd4, 32'hA0A0_0001};
    tbl[8]  = '{2'b00, 5'd0, 5'd0, 32'd0,         9'b000110011, 5'd5, 32'hB0B0_0002};
    tbl[9]  = '{2'b00, 5'd0, 5'd0, 32'd0,         9'b000111110, 5'd0, 32'hC0C0_0003};
    tbl[10] = '{2'b00, 5'd0, 5'd0, 32'd0,         9'b000000110, 5'd0, 32'd0};
    exp_w = '{30, 31, 0, 1};
`ifdef ARB_ROUND_ROBIN_EN
    exp_g = '{1, 2, 1};
`else
    exp_g = '{1, 1, 1};
`endif
    rst = 1'b1;
    ld_req = 1'b0;
    rd_req = 1'b0;
    ld_addr = '0;
    ld_len = '0;
    ld_data = '0;
    rd_addr = '0;
    rd_len = '0;
    repeat (2) @(posedge clk);
    #1;
    step(1'b1, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    chk("reset_mem_a", 32'(o.a), 32'd0);
    chk("reset_rd_data", o.rdata, 32'd0);

    // write A,B,C at 3..5 then read them back
    for (int i = 0; i < 11; i++) begin
      step(1'b0, tbl[i].req[1], tbl[i].addr, tbl[i].len, tbl[i].d, tbl[i].req[0], tbl[i].addr, tbl[i].len);
      chk($sformatf("tbl%0d_flags", i), 32'({o.ld_gnt, o.ld_ack, o.ld_done, o.rd_gnt, o.rd_valid, o.rd_done, o.csb, o.web}),
          32'(tbl[i].flags[8:1]));
      if (tbl[i].flags[0]) chk($sformatf("tbl%0d_addr", i), 32'(o.a), 32'(tbl[i].ea));
      chk($sformatf("tbl%0d_rdata", i), o.rdata, tbl[i].erd);
    end

    // address wrap 30,31,0,1
    step(1'b0, 1'b1, 5'd30, 5'd3, 32'd0, 1'b0, 5'd0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 5'd0, 5'd0, $urandom, 1'b0, 5'd0, 5'd0);
      if (o.ld_gnt) wq.push_back(int'(o.a));
    end
    idle(2);
    chk("wrap_count", 32'(wq.size()), 32'd4);
    for (int i = 0; i < 4 && i < wq.size(); i++) chk($sformatf("wrap_addr%0d", i), 32'(wq[i]), 32'(exp_w[i]));

    // both requesters held continuously
    step(1'b1, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    pl = 1'b0;
    pr = 1'b0;
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 1'b1, 5'd8, 5'd1, $urandom, 1'b1, 5'd20, 5'd1);
      if (o.ld_gnt && !pl) gq.push_back(1);
      if (o.rd_gnt && !pr) gq.push_back(2);
      pl = o.ld_gnt;
      pr = o.rd_gnt;
    end
    idle(5);
    chk("tie_count_ok", 32'(gq.size() >= 3), 32'd1);
    for (int i = 0; i < 3 && i < gq.size(); i++) chk($sformatf("tie_order%0d", i), 32'(gq[i]), 32'(exp_g[i]));

    // reset during the second word of a five-word read
    step(1'b1, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    step(1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 1'b1, 5'd10, 5'd4);
    step(1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    step(1'b1, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    step(1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    chk("abort_csb", 32'(o.csb), 32'd1);
    chk("abort_rd_gnt", 32'(o.rd_gnt), 32'd0);
    chk("abort_rd_done", 32'(o.rd_done), 32'd0);
    idle(6);

    // random traffic against the reference model
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), 5'($urandom),
           ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom),
           ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3)));
    end
    idle(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
